// File: rtl/rotate_addr_map.sv
// Rotates destination pixel coordinates about the frame centre to source word addresses (4-stage pipeline).
// Optional build macro ROT_BORDER_CLAMP_EN: clamp out-of-frame sources to the nearest border pixel.
module rotate_addr_map #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               addr_fifo_empty,
    input  logic [21:0]        addr_fifo_dout,
    output logic               addr_fifo_rd_en,
    input  logic signed [15:0] cos_in,
    input  logic signed [15:0] sin_in,
    input  logic               out_fifo_full,
    output logic               out_wr_en,
    output logic [20:0]        out_addr,
    output logic               out_in_range,
    output logic               frame_done
);

    localparam logic [11:0] HALF_H12 = 12'(H_ACTIVE / 2);
    localparam logic [11:0] HALF_V12 = 12'(V_ACTIVE / 2);
    localparam logic [15:0] HALF_H16 = 16'(H_ACTIVE / 2);
    localparam logic [15:0] HALF_V16 = 16'(V_ACTIVE / 2);
    localparam logic [15:0] H16      = 16'(H_ACTIVE);
    localparam logic [15:0] V16      = 16'(V_ACTIVE);
    localparam logic [20:0] LAST_PIX = 21'(H_ACTIVE * V_ACTIVE - 1);

    // Handshake: a coordinate moves one stage per cycle while its valid bit is set and
    // ce is high; with ce low every stage, valid bit and output holds unchanged.
    logic ce;
    logic pop;

    assign ce              = !out_fifo_full;
    assign pop             = ce && !addr_fifo_empty && !rst;
    assign addr_fifo_rd_en = pop;

    logic               v1;
    logic signed [11:0] dx1;
    logic signed [11:0] dy1;
    logic signed [15:0] cos_r;
    logic signed [15:0] sin_r;

    // A (0,0) pop loads new coefficients; stage 2 reads them a cycle later, so that pixel sees them.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            dx1   <= '0;
            dy1   <= '0;
            cos_r <= '0;
            sin_r <= '0;
        end else if (ce) begin
            v1  <= pop;
            dx1 <= $signed({1'b0, addr_fifo_dout[10:0]} - HALF_H12);
            dy1 <= $signed({1'b0, addr_fifo_dout[21:11]} - HALF_V12);
            if (pop && addr_fifo_dout == 22'd0) begin
                cos_r <= cos_in;
                sin_r <= sin_in;
            end
        end
    end

    logic               v2;
    logic signed [27:0] p_xc;
    logic signed [27:0] p_ys;
    logic signed [27:0] p_xs;
    logic signed [27:0] p_yc;

    always_ff @(posedge clk) begin
        if (rst) begin
            v2 <= 1'b0;
        end else if (ce) begin
            v2 <= v1;
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            p_xc <= 28'(dx1) * 28'(cos_r);
            p_ys <= 28'(dy1) * 28'(sin_r);
            p_xs <= 28'(dx1) * 28'(sin_r);
            p_yc <= 28'(dy1) * 28'(cos_r);
        end
    end

    logic signed [28:0] sum_x;
    logic signed [28:0] sum_y;
    logic signed [15:0] off_x;
    logic signed [15:0] off_y;
    logic               v3;
    logic signed [15:0] sx3;
    logic signed [15:0] sy3;

    // +8192 rounds the Q2.14 result to nearest before the arithmetic shift.
    assign sum_x = 29'(p_xc) + 29'(p_ys) + 29'sd8192;
    assign sum_y = 29'(p_yc) - 29'(p_xs) + 29'sd8192;
    assign off_x = 16'(sum_x >>> 14);
    assign off_y = 16'(sum_y >>> 14);

    always_ff @(posedge clk) begin
        if (rst) begin
            v3 <= 1'b0;
        end else if (ce) begin
            v3 <= v2;
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            sx3 <= $signed(HALF_H16 + off_x);
            sy3 <= $signed(HALF_V16 + off_y);
        end
    end

    logic        x_ok;
    logic        y_ok;
    logic [15:0] cx;
    logic [15:0] cy;
    logic [20:0] addr4;

    always_comb begin
        x_ok = !sx3[15] && (sx3[15:0] < H16);
        y_ok = !sy3[15] && (sy3[15:0] < V16);
        cx   = sx3;
        cy   = sy3;
`ifdef ROT_BORDER_CLAMP_EN
        if (sx3[15]) begin
            cx = '0;
        end else if (!x_ok) begin
            cx = H16 - 16'd1;
        end
        if (sy3[15]) begin
            cy = '0;
        end else if (!y_ok) begin
            cy = V16 - 16'd1;
        end
        addr4 = 21'(cy) * 21'(H_ACTIVE) + 21'(cx);
`else
        addr4 = (x_ok && y_ok) ? 21'(cy) * 21'(H_ACTIVE) + 21'(cx) : 21'd0;
`endif
    end

    logic        v4;
    logic [20:0] out_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            v4           <= 1'b0;
            out_addr     <= '0;
            out_in_range <= 1'b0;
        end else if (ce) begin
            v4           <= v3;
            out_addr     <= addr4;
            out_in_range <= x_ok && y_ok;
        end
    end

    assign out_wr_en  = v4 && ce && !rst;
    assign frame_done = out_wr_en && (out_cnt == LAST_PIX);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt <= '0;
        end else if (out_wr_en) begin
            out_cnt <= (out_cnt == LAST_PIX) ? 21'd0 : out_cnt + 21'd1;
        end
    end

endmodule

// File: tb/tb_rotate_addr_map.sv
// Bench for rotate_addr_map: directed vectors, stall/reset sequences, a small-frame instance and a random stream.
module tb_rotate_addr_map;

    localparam int H = 1280;
    localparam int V = 720;
`ifdef ROT_BORDER_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic               addr_fifo_empty;
    logic [21:0]        addr_fifo_dout;
    logic               addr_fifo_rd_en;
    logic signed [15:0] cos_in;
    logic signed [15:0] sin_in;
    logic               out_fifo_full;
    logic               out_wr_en;
    logic [20:0]        out_addr;
    logic               out_in_range;
    logic               frame_done;

    logic        s_empty;
    logic [21:0] s_dout;
    logic        s_rd_en;
    logic        s_full;
    logic        s_wr_en;
    logic [20:0] s_addr;
    logic        s_in_range;
    logic        s_frame_done;

    rotate_addr_map #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk(clk), .rst(rst),
        .addr_fifo_empty(addr_fifo_empty), .addr_fifo_dout(addr_fifo_dout),
        .addr_fifo_rd_en(addr_fifo_rd_en), .cos_in(cos_in), .sin_in(sin_in),
        .out_fifo_full(out_fifo_full), .out_wr_en(out_wr_en), .out_addr(out_addr),
        .out_in_range(out_in_range), .frame_done(frame_done)
    );

    rotate_addr_map #(.H_ACTIVE(8), .V_ACTIVE(4)) dut_s (
        .clk(clk), .rst(rst),
        .addr_fifo_empty(s_empty), .addr_fifo_dout(s_dout),
        .addr_fifo_rd_en(s_rd_en), .cos_in(cos_in), .sin_in(sin_in),
        .out_fifo_full(s_full), .out_wr_en(s_wr_en), .out_addr(s_addr),
        .out_in_range(s_in_range), .frame_done(s_frame_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    // reference model: rotation about the frame centre with plain integer arithmetic
    function automatic logic [21:0] ref_map(input int x, input int y, input int c, input int s,
                                            input int h, input int v);
        int dx, dy, sx, sy, cx, cy, a;
        bit inr;
        dx  = x - h / 2;
        dy  = y - v / 2;
        sx  = h / 2 + ((dx * c + dy * s + 8192) >>> 14);
        sy  = v / 2 + ((dy * c - dx * s + 8192) >>> 14);
        inr = (sx >= 0) && (sx < h) && (sy >= 0) && (sy < v);
        cx  = (sx < 0) ? 0 : ((sx >= h) ? h - 1 : sx);
        cy  = (sy < 0) ? 0 : ((sy >= v) ? v - 1 : sy);
        if (CLAMP) a = cy * h + cx;
        else       a = inr ? sy * h + sx : 0;
        return {inr, a[20:0]};
    endfunction

    // upstream FIFO driver (first-word-fall-through)
    logic [21:0] in_q[$];
    logic        popped;

    initial begin
        addr_fifo_empty = 1'b1;
        addr_fifo_dout  = '0;
        forever begin
            @(posedge clk);
            popped = addr_fifo_rd_en;
            #1;
            if (popped && in_q.size() > 0) void'(in_q.pop_front());
            addr_fifo_empty = (in_q.size() == 0);
            addr_fifo_dout  = (in_q.size() == 0) ? 22'd0 : in_q[0];
        end
    end

    // scoreboard
    logic [21:0] exp_q[$];
    int          pop_cyc_q[$];
    int          pop_stall_q[$];
    logic [20:0] out_log[$];
    logic [20:0] ref_log[$];
    int          cyc = 0;
    int          stall_cnt = 0;
    int          m_cos = 0;
    int          m_sin = 0;
    int          wr_cnt = 0;
    int          last_lat = 0;
    logic [20:0] last_addr = '0;
    logic        last_inr = 1'b0;
    logic [20:0] hold_addr = '0;
    logic        hold_inr = 1'b0;
    logic        prev_full = 1'b0;
    logic [21:0] e;
    int          p, ps;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rd_en_in_rst", addr_fifo_rd_en, 0);
                check("wr_en_in_rst", out_wr_en, 0);
                exp_q.delete();
                pop_cyc_q.delete();
                pop_stall_q.delete();
                m_cos     = 0;
                m_sin     = 0;
                prev_full = 1'b0;
            end else begin
                if (addr_fifo_rd_en) begin
                    if (addr_fifo_dout == 22'd0) begin
                        m_cos = cos_in;
                        m_sin = sin_in;
                    end
                    exp_q.push_back(ref_map(int'(addr_fifo_dout[10:0]), int'(addr_fifo_dout[21:11]),
                                            m_cos, m_sin, H, V));
                    pop_cyc_q.push_back(cyc);
                    pop_stall_q.push_back(stall_cnt);
                end
                if (out_fifo_full) begin
                    check("stall_rd_en", addr_fifo_rd_en, 0);
                    check("stall_wr_en", out_wr_en, 0);
                    if (prev_full) begin
                        check("stall_hold_addr", out_addr, hold_addr);
                        check("stall_hold_in_range", out_in_range, hold_inr);
                    end
                    hold_addr = out_addr;
                    hold_inr  = out_in_range;
                    stall_cnt++;
                end
                if (out_wr_en) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_write_pending", exp_q.size(), 1);
                    end else begin
                        e  = exp_q.pop_front();
                        p  = pop_cyc_q.pop_front();
                        ps = pop_stall_q.pop_front();
                        check("addr", out_addr, e[20:0]);
                        check("in_range", out_in_range, e[21]);
                        check("latency", cyc - p, 4 + stall_cnt - ps);
                        check("frame_done_low", frame_done, 0);
                        last_addr = out_addr;
                        last_inr  = out_in_range;
                        last_lat  = cyc - p;
                        out_log.push_back(out_addr);
                        wr_cnt++;
                    end
                end
                prev_full = out_fifo_full;
            end
            cyc++;
        end
    end

    // small-frame monitor: 0-degree rotation, writes must be 0..31 in order
    int s_wr_cnt = 0;
    int s_fd_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && s_wr_en) begin
                check("small_addr", s_addr, s_wr_cnt);
                check("small_in_range", s_in_range, 1);
                check("small_frame_done", s_frame_done, (s_wr_cnt == 31));
                if (s_frame_done) s_fd_cnt++;
                s_wr_cnt++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(posedge clk);
            if (in_q.size() == 0 && exp_q.size() == 0) done = 1'b1;
        end
        check(name, done, 1);
        #1;
    endtask

    typedef struct {
        int x;
        int y;
        int c;
        int s;
        int exp_addr;
        bit exp_inr;
    } vec_t;
    vec_t vt[9];

    task automatic apply_vec(input int i);
        int start;
        bit got;
        cos_in = 16'(vt[i].c);
        sin_in = 16'(vt[i].s);
        start  = wr_cnt;
        in_q.push_back({11'(vt[i].y), 11'(vt[i].x)});
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk);
            if (wr_cnt != start) got = 1'b1;
        end
        check($sformatf("vec%0d_written", i), got, 1);
        check($sformatf("vec%0d_addr", i), last_addr, vt[i].exp_addr);
        check($sformatf("vec%0d_in_range", i), last_inr, vt[i].exp_inr);
        check($sformatf("vec%0d_latency", i), last_lat, 4);
        #1;
    endtask

    task automatic run_stream(input bit stall);
        out_log.delete();
        cos_in = 16'sd11585;
        sin_in = -16'sd11585;
        in_q.push_back(22'd0);
        for (int i = 1; i < 12; i++) in_q.push_back({11'(300 + 37 * i), 11'(500 + 53 * i)});
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            out_fifo_full = stall && (k >= 4) && (k < 7);
        end
        out_fifo_full = 1'b0;
        drain(stall ? "stream_stall_drain" : "stream_drain");
    endtask

    initial begin
        rst           = 1'b1;
        cos_in        = 16'sd16384;
        sin_in        = '0;
        out_fifo_full = 1'b0;
        s_empty       = 1'b1;
        s_dout        = '0;
        s_full        = 1'b0;
        in_q.push_back(22'd0);

        vt[0] = '{0, 0, 16384, 0, 0, 1'b1};
        vt[1] = '{100, 50, 16384, 0, 64100, 1'b1};
        vt[2] = '{0, 0, 0, 16384, CLAMP ? 920600 : 0, 1'b0};
        vt[3] = '{640, 360, 0, 16384, 461440, 1'b1};
        vt[4] = '{740, 360, 0, 16384, 333440, 1'b1};
        vt[5] = '{0, 0, -16384, 0, CLAMP ? 921599 : 0, 1'b0};
        vt[6] = '{1279, 719, -16384, 0, 1281, 1'b1};
        vt[7] = '{0, 0, 11585, 11585, CLAMP ? 714240 : 0, 1'b0};
        vt[8] = '{700, 400, 11585, 11585, 443591, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_addr", out_addr, 0);
        check("rst_out_in_range", out_in_range, 0);
        check("rst_out_wr_en", out_wr_en, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_rd_en", addr_fifo_rd_en, 0);
        check("rst_out_cnt", dut.out_cnt, 0);
        rst = 1'b0;
        drain("initial_drain");

        for (int i = 0; i < 9; i++) apply_vec(i);

        run_stream(1'b0);
        ref_log = out_log;
        run_stream(1'b1);
        check("stream_len", out_log.size(), ref_log.size());
        for (int i = 0; i < 12 && i < out_log.size() && i < ref_log.size(); i++)
            check($sformatf("stream_seq%0d", i), out_log[i], ref_log[i]);

        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            out_fifo_full = ($urandom_range(0, 3) == 0);
            cos_in        = 16'($urandom_range(0, 32768)) - 16'sd16384;
            sin_in        = 16'($urandom_range(0, 32768)) - 16'sd16384;
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 7) == 0) in_q.push_back(22'd0);
                else in_q.push_back({11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047))});
            end
        end
        out_fifo_full = 1'b0;
        drain("random_drain");

        cos_in = 16'sd16384;
        sin_in = '0;
        for (int i = 1; i <= 5; i++) in_q.push_back({11'(10 * i), 11'(10 * i)});
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("wr_en_first_cycle_after_rst", out_wr_en, 0);
        @(posedge clk);
        #1;
        in_q.push_back(22'd0);
        in_q.push_back({11'd50, 11'd100});
        drain("post_rst_drain");
        check("post_rst_addr", last_addr, 64100);
        check("post_rst_in_range", last_inr, 1);

        cos_in = 16'sd16384;
        sin_in = '0;
        for (int i = 0; i < 32; i++) begin
            s_dout  = {11'(i / 8), 11'(i % 8)};
            s_empty = 1'b0;
            @(posedge clk);
            #1;
        end
        s_empty = 1'b1;
        for (int k = 0; k < 20 && s_wr_cnt < 32; k++) @(posedge clk);
        #1;
        check("small_write_count", s_wr_cnt, 32);
        check("small_frame_done_count", s_fd_cnt, 1);
        check("small_out_cnt_wrapped", dut_s.out_cnt, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rotate_addr_map.md
ROTATE_ADDR_MAP -- requirements
Module: rotate_addr_map

Interface
REQ-001 Parameters (name, default, meaning): H_ACTIVE, 1280, output frame width in pixels; V_ACTIVE, 720, output frame height in pixels.
REQ-002 clk  input  1  single clock; all logic is clocked on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 addr_fifo_empty  input  1  upstream destination-address FIFO is empty (first-word-fall-through).
REQ-005 addr_fifo_dout  input  22  {y[10:0], x[10:0]}; a destination pixel coordinate, valid whenever addr_fifo_empty=0.
REQ-006 addr_fifo_rd_en  output  1  pop strobe to the upstream FIFO.
REQ-007 cos_in, sin_in  input  16 each  signed Q2.14 rotation coefficients.
REQ-008 out_fifo_full  input  1  downstream read-request FIFO is full.
REQ-009 out_wr_en  output  1  write strobe to the downstream FIFO.
REQ-010 out_addr  output  21  source pixel word address, sy*H_ACTIVE+sx.
REQ-011 out_in_range  output  1  1 = source pixel lies inside the frame; 0 = the consumer writes black.
REQ-012 frame_done  output  1  one-cycle pulse when the last pixel of a frame is written out.

Function
REQ-013 Global enable ce = !out_fifo_full; every pipeline register and valid bit advances only when ce=1.
REQ-014 addr_fifo_rd_en = ce && !addr_fifo_empty; the block captures addr_fifo_dout in the same cycle.
REQ-015 S1: dx = x-H_ACTIVE/2, dy = y-V_ACTIVE/2, each 12-bit signed.
REQ-016 S2: register the four products dx*cos, dy*sin, dx*sin, dy*cos, each 28-bit signed.
REQ-017 S3: sx = H_ACTIVE/2 + ((dx*cos + dy*sin + 8192) >>> 14); sy = V_ACTIVE/2 + ((dy*cos - dx*sin + 8192) >>> 14).
REQ-018 S3 arithmetic: 29-bit sums, arithmetic shift, 16-bit signed results, no saturation before the range check.
REQ-019 S4: out_in_range = (0<=sx<H_ACTIVE) && (0<=sy<V_ACTIVE); out_addr = sy*H_ACTIVE+sx when in range, otherwise 0.
REQ-020 out_wr_en = valid_S4 && !out_fifo_full; out_addr and out_in_range are held stable while stalled.
REQ-021 Latency: a coordinate popped in cycle N drives out_wr_en in cycle N+4 when there is no stall; each stall cycle adds exactly one cycle.
REQ-022 Coordinates are neither lost, duplicated nor reordered under any stall pattern.
REQ-023 Coefficients are latched into working registers when the popped coordinate is (0,0).
REQ-024 That (0,0) pixel uses the newly latched coefficients; all other pixels use the held values.
REQ-025 out_cnt counts out_wr_en pulses; at count H_ACTIVE*V_ACTIVE-1 the write asserts frame_done and out_cnt wraps to 0.
REQ-026 If empty and full occur simultaneously, no pop takes place and the pipeline holds.

Reset
REQ-027 On rst=1 at a clock edge, the following all go to 0: every valid bit, out_cnt, the latched coefficients, addr_fifo_rd_en, out_wr_en, out_addr, out_in_range and frame_done.
REQ-028 Reset mid-frame discards in-flight coordinates; no out_wr_en is issued in the first cycle after rst falls.
REQ-029 While rst=1, rd_en stays at 0.

Configuration
REQ-030 Macro ROT_BORDER_CLAMP_EN defined: out-of-range sx, sy are clamped to [0,H_ACTIVE-1] and [0,V_ACTIVE-1], and out_addr is formed from the clamped values.
REQ-031 With ROT_BORDER_CLAMP_EN, out_in_range still reports the unclamped test.
REQ-032 ROT_BORDER_CLAMP_EN undefined: out_addr=0 for out-of-range pixels, as in REQ-019.

Verification
REQ-033 cos=16384, sin=0, push (0,0) then (100,50) -> out_addr 0 then 64100, in_range 1, each 4 cycles after its pop.
REQ-034 cos=0, sin=16384, push (0,0), (640,360) -> first: in_range 0, addr 0 (clamp build: addr 920600); second: addr 461440, in_range 1.
REQ-035 Continuous stream, out_fifo_full high for 3 cycles mid-stream -> rd_en and out_wr_en low for those cycles, output sequence identical to the no-stall run.
REQ-036 H_ACTIVE=8, V_ACTIVE=4, 0 degrees, 32 coordinates -> out_addr 0..31 in order, frame_done only on the 32nd write, out_cnt back to 0.
REQ-037 rst pulsed with 3 coordinates in flight -> no out_wr_en for those coordinates; next (0,0) relatches the coefficients and yields the correct address.
